// File: rtl/thresh_monitor_pkg.sv
// Shared definitions for the threshold monitor: FSM state encoding and run-counter width.
package thresh_monitor_pkg;

    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        ST_BELOW   = 2'b00,
        ST_PEND_UP = 2'b01,
        ST_ABOVE   = 2'b10,
        ST_PEND_DN = 2'b11
    } state_t;

endpackage

// File: rtl/mag_cmp4.sv
// Unsigned 4-bit magnitude comparator; all outputs are low while disabled.
module mag_cmp4 (
    input  logic       i_en,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);

    assign o_gt = i_en & (i_a >  i_b);
    assign o_eq = i_en & (i_a == i_b);
    assign o_lt = i_en & (i_a <  i_b);

endmodule

// File: rtl/thresh_monitor.sv
// Debounced threshold crossing monitor with hysteresis on equality and a saturating rise counter.
module thresh_monitor
    import thresh_monitor_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [3:0]       i_thr,
    input  logic [3:0]       i_sample,
    input  logic             i_valid,
    input  logic             i_clear,
    output logic             o_above,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [RUN_W-1:0] DEB_L = RUN_W'(DEBOUNCE);

    state_t             r_state;
    state_t             w_nextState;
    logic [RUN_W-1:0]   r_run;
    logic [RUN_W-1:0]   w_nextRun;
    logic [RUN_W-1:0]   w_runInc;
    logic [3:0]         r_thr;
    logic               r_above;
    logic               r_rise;
    logic               r_fall;
    logic [CNT_W-1:0]   r_count;
    logic               w_gt;
    logic               w_eq;
    logic               w_lt;
    logic               w_accept;
    logic               w_riseEvt;
    logic               w_fallEvt;

    mag_cmp4 u_cmp (
        .i_en (i_en),
        .i_a  (i_sample),
        .i_b  (r_thr),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    // The comparator only yields a result while enabled, so this also folds in i_en.
    assign w_accept = i_valid & (w_gt | w_eq | w_lt);
    assign w_runInc = r_run + RUN_W'(1);

    always_comb begin
        w_nextState = r_state;
        w_nextRun   = r_run;
        w_riseEvt   = 1'b0;
        w_fallEvt   = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_BELOW: begin
                    if (w_gt) begin
                        if (DEBOUNCE == 1) begin
                            w_nextState = ST_ABOVE;
                            w_nextRun   = '0;
                            w_riseEvt   = 1'b1;
                        end else begin
                            w_nextState = ST_PEND_UP;
                            w_nextRun   = RUN_W'(1);
                        end
                    end
                end
                ST_PEND_UP: begin
                    if (w_gt) begin
                        if (w_runInc == DEB_L) begin
                            w_nextState = ST_ABOVE;
                            w_nextRun   = '0;
                            w_riseEvt   = 1'b1;
                        end else begin
                            w_nextRun   = w_runInc;
                        end
                    end else if (w_lt) begin
                        w_nextState = ST_BELOW;
                        w_nextRun   = '0;
                    end
                end
                ST_ABOVE: begin
                    if (w_lt) begin
                        if (DEBOUNCE == 1) begin
                            w_nextState = ST_BELOW;
                            w_nextRun   = '0;
                            w_fallEvt   = 1'b1;
                        end else begin
                            w_nextState = ST_PEND_DN;
                            w_nextRun   = RUN_W'(1);
                        end
                    end
                end
                ST_PEND_DN: begin
                    if (w_lt) begin
                        if (w_runInc == DEB_L) begin
                            w_nextState = ST_BELOW;
                            w_nextRun   = '0;
                            w_fallEvt   = 1'b1;
                        end else begin
                            w_nextRun   = w_runInc;
                        end
                    end else if (w_gt) begin
                        w_nextState = ST_ABOVE;
                        w_nextRun   = '0;
                    end
                end
                default: begin
                    w_nextState = ST_BELOW;
                    w_nextRun   = '0;
                end
            endcase
        end
    end

    // Pulses are re-evaluated every cycle so they drop after one clock even when disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BELOW;
            r_run   <= '0;
            r_thr   <= 4'h0;
            r_above <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_run   <= w_nextRun;
            r_above <= (w_nextState == ST_ABOVE) || (w_nextState == ST_PEND_DN);
            r_rise  <= w_riseEvt;
            r_fall  <= w_fallEvt;
            if (i_en && i_load) begin
                r_thr <= i_thr;
            end
            if (i_clear) begin
                r_count <= '0;
            end else if (w_riseEvt && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_above = r_above;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_count = r_count;

endmodule

// File: tb/tb_thresh_monitor.sv
// Directed plus randomized bench for thresh_monitor against a level/run-length reference model.
module tb_thresh_monitor;

    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rstN;
    logic       en;
    logic       load;
    logic [3:0] thr;
    logic [3:0] sample;
    logic       valid;
    logic       clear;

    logic       above,    rise,    fall;
    logic [7:0] count;
    logic       aboveSat, riseSat, fallSat;
    logic [1:0] countSat;

    int nAsserts = 0;
    int nFails   = 0;

    bit         mLevel;
    int         mRun;
    logic [3:0] mThr;
    int         mCount;
    int         mCountSat;
    bit         mRise;
    bit         mFall;

    always #5 clk = ~clk;

    thresh_monitor #(.DEBOUNCE(DEB), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_load(load), .i_thr(thr),
        .i_sample(sample), .i_valid(valid), .i_clear(clear),
        .o_above(above), .o_rise(rise), .o_fall(fall), .o_count(count)
    );

    thresh_monitor #(.DEBOUNCE(DEB), .CNT_W(2)) dutSat (
        .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_load(load), .i_thr(thr),
        .i_sample(sample), .i_valid(valid), .i_clear(clear),
        .o_above(aboveSat), .o_rise(riseSat), .o_fall(fallSat), .o_count(countSat)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mLevel = 0; mRun = 0; mThr = 4'h0;
        mCount = 0; mCountSat = 0; mRise = 0; mFall = 0;
    endtask

    // A crossing needs DEB consecutive qualifying samples; the opposite side resets the run, equality is ignored.
    task automatic modelStep();
        mRise = 0;
        mFall = 0;
        if (en && valid) begin
            if (!mLevel) begin
                if (sample > mThr) begin
                    mRun++;
                    if (mRun == DEB) begin mLevel = 1; mRun = 0; mRise = 1; end
                end else if (sample < mThr) begin
                    mRun = 0;
                end
            end else begin
                if (sample < mThr) begin
                    mRun++;
                    if (mRun == DEB) begin mLevel = 0; mRun = 0; mFall = 1; end
                end else if (sample > mThr) begin
                    mRun = 0;
                end
            end
        end
        if (en && load) mThr = thr;
        if (clear) begin
            mCount = 0;
            mCountSat = 0;
        end else if (mRise) begin
            if (mCount < 255) mCount++;
            if (mCountSat < 3) mCountSat++;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_above"}, 32'(above), 32'(mLevel));
        checkVal({tag, "_rise"},  32'(rise),  32'(mRise));
        checkVal({tag, "_fall"},  32'(fall),  32'(mFall));
        checkVal({tag, "_count"}, 32'(count), 32'(mCount));
        checkVal({tag, "_csat"},  32'(countSat), 32'(mCountSat));
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic [3:0] t,
                                 input logic [3:0] s, input logic v, input logic c,
                                 input string tag);
        en = e; load = l; thr = t; sample = s; valid = v; clear = c;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic sampleIn(input logic [3:0] s, input string tag);
        applyStimulus(1'b1, 1'b0, 4'h0, s, 1'b1, 1'b0, tag);
    endtask

    initial begin
        $display("[TB] starting thresh_monitor bench");
        en = 0; load = 0; thr = 0; sample = 0; valid = 0; clear = 0;
        rstN = 1'b0;
        modelReset();
        #12;
        checkOutput("reset");
        rstN = 1'b1;
        #1;

        // Basic rise after three Greater samples.
        applyStimulus(1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0, "load5");
        sampleIn(4'd6, "s6");
        sampleIn(4'd7, "s7");
        checkVal("pre_rise", 32'(rise), 32'd0);
        sampleIn(4'd8, "s8");
        checkVal("rise_after_8", 32'(rise), 32'd1);
        checkVal("above_after_8", 32'(above), 32'd1);
        checkVal("count_after_8", 32'(count), 32'd1);
        sampleIn(4'd8, "s8b");
        checkVal("rise_one_cycle", 32'(rise), 32'd0);

        // Fall through a Valid gap.
        sampleIn(4'd2, "d2a");
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd2, 1'b0, 1'b0, "gap");
        sampleIn(4'd2, "d2b");
        sampleIn(4'd2, "d2c");
        checkVal("fall_after_2", 32'(fall), 32'd1);
        checkVal("above_low", 32'(above), 32'd0);

        // Equality holds the run.
        sampleIn(4'd6, "h6");
        sampleIn(4'd5, "h5a");
        sampleIn(4'd5, "h5b");
        sampleIn(4'd7, "h7");
        checkVal("eq_no_rise", 32'(rise), 32'd0);
        sampleIn(4'd9, "h9");
        checkVal("eq_rise", 32'(rise), 32'd1);
        sampleIn(4'd2, "e2a");
        sampleIn(4'd2, "e2b");
        sampleIn(4'd2, "e2c");
        sampleIn(4'd6, "b6");
        sampleIn(4'd3, "b3");
        checkVal("broken_run", 32'(above), 32'd0);

        // Load and sample in the same cycle: old threshold applies.
        applyStimulus(1'b1, 1'b1, 4'd9, 4'd7, 1'b1, 1'b0, "ld9_s7");
        sampleIn(4'd7, "s7_less");
        sampleIn(4'd10, "t10a");
        sampleIn(4'd10, "t10b");
        checkVal("old_thr_reset_run", 32'(rise), 32'd0);
        sampleIn(4'd10, "t10c");
        checkVal("new_thr_rise", 32'(rise), 32'd1);
        for (int i = 0; i < 3; i++) sampleIn(4'd2, "f2");

        // Saturation of the narrow counter, then Clear against a Rise.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) sampleIn(4'd12, "sat_up");
            for (int i = 0; i < 3; i++) sampleIn(4'd1, "sat_dn");
        end
        checkVal("sat_count", 32'(countSat), 32'd3);
        sampleIn(4'd12, "cl_a");
        sampleIn(4'd12, "cl_b");
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd12, 1'b1, 1'b1, "clr_rise");
        checkVal("clr_rise_count", 32'(countSat), 32'd0);
        checkVal("clr_rise_pulse", 32'(rise), 32'd1);

        // Disabled block freezes but still clears.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'd15, 4'd1, 1'b1, 1'b0, "en0");
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 1'b0, 1'b1, "en0_clr");
        for (int i = 0; i < 3; i++) sampleIn(4'd1, "dn_again");
        sampleIn(4'd12, "pre_rst_a");
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd12, 1'b1, 1'b1, "pre_rst_clr");
        for (int i = 0; i < 3; i++) sampleIn(4'd1, "dn3");
        for (int i = 0; i < 3; i++) sampleIn(4'd12, "up3");
        checkVal("pre_rst_count", 32'(count), 32'(mCount));

        // Asynchronous reset between edges in the middle of a pending rise.
        for (int i = 0; i < 3; i++) sampleIn(4'd1, "dn4");
        sampleIn(4'd12, "pend_up");
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst");
        #2;
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd9, 4'd0, 1'b0, 1'b0, "reload9");
        sampleIn(4'd12, "fresh_a");
        sampleIn(4'd12, "fresh_b");
        checkVal("fresh_no_rise", 32'(rise), 32'd0);
        sampleIn(4'd12, "fresh_c");
        checkVal("fresh_rise", 32'(rise), 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(logic'($urandom_range(0, 9) != 0),
                          logic'($urandom_range(0, 15) == 0),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          logic'($urandom_range(0, 3) != 0),
                          logic'($urandom_range(0, 31) == 0),
                          "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/thresh_monitor.md
THRESH_MONITOR -- requirements
Module: thresh_monitor

Interface
REQ-001 Parameter DEBOUNCE, default 3, sets the consecutive qualifying samples needed to change state; legal range 1..15.
REQ-002 Parameter CNT_W, default 8, sets the width of the rising-event counter.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 En  input  1  block enable; low freezes all state.
REQ-006 Load  input  1  when high, the threshold register captures Thr.
REQ-007 Thr  input  4  threshold value (unsigned).
REQ-008 Sample  input  4  data sample (unsigned).
REQ-009 Valid  input  1  Sample is qualified this cycle.
REQ-010 Clear  input  1  synchronous clear of Count.
REQ-011 Above  output  1  registered; high while the FSM is in ABOVE or PEND_DN.
REQ-012 Rise  output  1  one-cycle pulse on entry to ABOVE.
REQ-013 Fall  output  1  one-cycle pulse on entry to BELOW from PEND_DN.
REQ-014 Count  output  CNT_W  number of Rise events, saturating.

Function
REQ-015 Comparison SHALL be unsigned 4-bit Sample vs. the registered threshold, giving exactly one of Greater/Equal/Less per accepted sample.
REQ-016 A sample SHALL be accepted only when En=1 and Valid=1; otherwise the FSM, run counter and outputs other than pulses SHALL hold.
REQ-017 FSM states SHALL be BELOW, PEND_UP, ABOVE and PEND_DN, with a 4-bit run counter.
REQ-018 In BELOW, Greater SHALL set run=1 and go to PEND_UP; if DEBOUNCE=1, it SHALL go directly to ABOVE.
REQ-019 In PEND_UP, Greater SHALL increment run, and on reaching DEBOUNCE go to ABOVE; Less SHALL clear run and return to BELOW; Equal SHALL hold state and run (hysteresis).
REQ-020 ABOVE and PEND_DN SHALL mirror REQ-018/019 with Less as the qualifying result and BELOW as the target.
REQ-021 Rise, Fall and Above SHALL be registered, appearing the cycle after the accepting edge; pulses SHALL last exactly one cycle.
REQ-022 Load SHALL update the threshold at the edge; a sample accepted in the same cycle SHALL compare against the old threshold.
REQ-023 Load SHALL NOT alter FSM state or run.
REQ-024 Count SHALL increment by 1 on each Rise and hold at 2^CNT_W-1.
REQ-025 Clear SHALL take priority over a simultaneous increment, yielding Count=0.
REQ-026 Clear SHALL act regardless of En.
REQ-027 With En=0, Rise and Fall SHALL be 0.

Reset
REQ-028 Rst_n low SHALL asynchronously force: state=BELOW, run=0, threshold=4'h0, Above=0, Rise=0, Fall=0, Count=0.
REQ-029 Reset mid-debounce SHALL discard partial runs.
REQ-030 After deassertion, the first accepted sample SHALL be treated as from BELOW.

Structure
REQ-031 State encodings (2-bit) and the run-counter width SHALL reside in shared package thresh_monitor_pkg.
REQ-032 Magnitude comparison SHALL be a single combinational sub-module, mag_cmp4 (Greater/Equal/Less with enable tied to En); all sequential logic SHALL reside in thresh_monitor.

Verification
REQ-033 Reset, Load Thr=5, then Valid samples 6,7,8 -> Rise one cycle after the 8, Above=1, Count=1.
REQ-034 Thr=5, samples 6,5,5,7,9 -> Equal holds run, Rise after 9; samples 6,3 -> FSM stays BELOW, no Rise.
REQ-035 In ABOVE, samples 2,2,2 -> Fall one cycle after the third 2, Above=0; Valid gaps between samples do not break the run.
REQ-036 CNT_W=2, four full rise/fall cycles -> Count saturates at 3; Clear coincident with a Rise -> Count=0.
REQ-037 Load Thr=9 in the same cycle as Sample=7 (old Thr=5) -> counts as Greater; next Sample=7 counts as Less.
REQ-038 Rst_n pulsed low mid-PEND_UP (asynchronous, between edges) -> outputs zero immediately; three fresh Greater samples are needed for Rise.
